qu_frontend_ctrl: RTL and testbench

QU_FRONTEND_CTRL -- requirements
Module: qu_frontend_ctrl

---
 rtl/qu_frontend_ctrl.sv | 101 ++++++++++
 tb/tb_qu_frontend_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qu_frontend_ctrl.sv
// Frontend pipeline controller: holds all stages after reset, chains stage
// stalls while running, and sequences redirects as a flush hold plus one redirect pulse.
module qu_frontend_ctrl #(
    parameter int          PC_WIDTH     = 32,
    parameter int          BOOT_CYCLES  = 4,
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch,
    input  logic                jump,
    input  logic                exception,
    input  logic [PC_WIDTH-1:0] pc_override,
    input  logic                if_id_full,
    input  logic                id_mp_full,
    input  logic                mp_rn_full,
    input  logic                rn_busy,
    input  logic                sched_req,
    output logic                if_stall,
    output logic                id_stall,
    output logic                mp_stall,
    output logic                rn_stall,
    output logic                flush,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                schedule_en,
    output logic [15:0]         flush_count
);
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH, ST_REDIRECT} state_t;

    localparam logic [7:0] BOOT_LOAD  = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [PC_WIDTH-1:0]   r_redirect_pc;
    logic [15:0]           r_flush_count;

    logic                  w_run;
    logic                  w_req;
    logic [PC_WIDTH-1:0]   w_exc_pc;
    logic [PC_WIDTH-1:0]   w_target;
    logic [15:0]           w_count_inc;

    assign w_run       = (r_state == ST_RUN);
    assign w_req       = branch | jump | exception;
    assign w_exc_pc    = PC_WIDTH'(EXC_VECTOR);
    // Exception wins; branch and jump share the same override target.
    assign w_target    = exception ? w_exc_pc : pc_override;
    assign w_count_inc = (r_flush_count == 16'hFFFF) ? r_flush_count : r_flush_count + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_BOOT;
            r_cnt         <= BOOT_LOAD;
            r_redirect_pc <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (r_cnt == 8'd0) r_state <= ST_RUN;
                    else               r_cnt   <= r_cnt - 8'd1;
                end
                ST_RUN: begin
                    if (w_req) begin
                        r_state       <= ST_FLUSH;
                        r_redirect_pc <= w_target;
                        r_cnt         <= FLUSH_LOAD;
                        r_flush_count <= w_count_inc;
                    end
                end
                ST_FLUSH: begin
                    // Only an exception may retarget an in-flight flush; it restarts the hold.
                    if (exception) begin
                        r_redirect_pc <= w_exc_pc;
                        r_cnt         <= FLUSH_LOAD;
                        r_flush_count <= w_count_inc;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= ST_REDIRECT;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_REDIRECT: r_state <= ST_RUN;
                default:     r_state <= ST_BOOT;
            endcase
        end
    end

    // Outside RUN rn_stall is forced high, which propagates up the whole chain.
    assign rn_stall       = w_run ? rn_busy : 1'b1;
    assign mp_stall       = rn_stall | mp_rn_full;
    assign id_stall       = mp_stall | id_mp_full;
    assign if_stall       = id_stall | if_id_full;
    assign schedule_en    = w_run & sched_req & ~rn_busy;
    assign flush          = (r_state == ST_FLUSH);
    assign redirect_valid = (r_state == ST_REDIRECT);
    assign redirect_pc    = r_redirect_pc;
    assign flush_count    = r_flush_count;
endmodule

// File: tb/tb_qu_frontend_ctrl.sv
// Bench for qu_frontend_ctrl: directed scenarios plus randomized traffic
// compared against a phase-countdown reference model.
module tb_qu_frontend_ctrl;
    localparam int          PCW  = 32;
    localparam int          BOOT = 4;
    localparam int          FL   = 3;
    localparam logic [31:0] EXC  = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic branch, jump, exception;
    logic [PCW-1:0] pc_override;
    logic if_id_full, id_mp_full, mp_rn_full, rn_busy, sched_req;
    logic if_stall, id_stall, mp_stall, rn_stall, flush, redirect_valid, schedule_en;
    logic [PCW-1:0] redirect_pc;
    logic [15:0] flush_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qu_frontend_ctrl #(
        .PC_WIDTH(PCW), .BOOT_CYCLES(BOOT), .FLUSH_CYCLES(FL), .EXC_VECTOR(EXC)
    ) dut (
        .clk(clk), .rst(rst),
        .branch(branch), .jump(jump), .exception(exception), .pc_override(pc_override),
        .if_id_full(if_id_full), .id_mp_full(id_mp_full), .mp_rn_full(mp_rn_full),
        .rn_busy(rn_busy), .sched_req(sched_req),
        .if_stall(if_stall), .id_stall(id_stall), .mp_stall(mp_stall), .rn_stall(rn_stall),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .schedule_en(schedule_en), .flush_count(flush_count)
    );

    // Reference model: cycles left in boot, cycles left of flush hold, pending redirect pulse.
    typedef struct {
        int          boot_left;
        int          flush_left;
        bit          redir;
        int          count;
        logic [31:0] pc;
    } model_t;

    model_t m;

    function automatic model_t reset_m();
        model_t r;
        r.boot_left = BOOT; r.flush_left = 0; r.redir = 0; r.count = 0; r.pc = '0;
        return r;
    endfunction

    function automatic int sat_inc(int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    function automatic model_t next_m(model_t c);
        model_t n = c;
        if (c.boot_left > 0) begin
            n.boot_left = c.boot_left - 1;
        end else if (c.flush_left > 0) begin
            if (exception) begin
                n.pc = EXC; n.flush_left = FL; n.count = sat_inc(c.count);
            end else begin
                n.flush_left = c.flush_left - 1;
                if (n.flush_left == 0) n.redir = 1;
            end
        end else if (c.redir) begin
            n.redir = 0;
        end else if (branch | jump | exception) begin
            n.flush_left = FL;
            n.pc = exception ? EXC : pc_override;
            n.count = sat_inc(c.count);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= reset_m();
        else      m <= next_m(m);
    end

    task automatic clear_inputs();
        branch = 0; jump = 0; exception = 0; pc_override = '0;
        if_id_full = 0; id_mp_full = 0; mp_rn_full = 0; rn_busy = 0; sched_req = 0;
    endtask

    task automatic tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 0; clear_inputs(); tick(); rst = 1;
        repeat (BOOT) tick();
    endtask

    task automatic test_reset();
        #1 rst = 0; #1;
        checks++;
        if ({if_stall, id_stall, mp_stall, rn_stall} !== 4'b1111) begin
            failures++; $display("FAIL reset_stalls got=%b exp=1111", {if_stall, id_stall, mp_stall, rn_stall});
        end
        checks++;
        if ({flush, redirect_valid, schedule_en} !== 3'b000) begin
            failures++; $display("FAIL reset_ctl got=%b exp=000", {flush, redirect_valid, schedule_en});
        end
        checks++;
        if (redirect_pc !== '0 || flush_count !== 16'd0) begin
            failures++; $display("FAIL reset_regs pc=%h cnt=%h exp=0/0", redirect_pc, flush_count);
        end
    endtask

    task automatic test_boot();
        int stalled;
        tick();
        rst = 1; branch = 1; pc_override = 32'h0000_5000;
        stalled = 0;
        for (int i = 0; i < BOOT; i++) begin
            if ({if_stall, id_stall, mp_stall, rn_stall, schedule_en} === 5'b11110) stalled++;
            sched_req = 1;
            tick();
        end
        branch = 0; sched_req = 0; #1;
        checks++;
        if (stalled !== BOOT) begin
            failures++; $display("FAIL boot_stalled_cycles got=%0d exp=%0d", stalled, BOOT);
        end
        checks++;
        if ({if_stall, id_stall, mp_stall, rn_stall, flush} !== 5'b00000) begin
            failures++; $display("FAIL boot_to_run got=%b exp=00000", {if_stall, id_stall, mp_stall, rn_stall, flush});
        end
        checks++;
        if (flush_count !== 16'd0 || redirect_pc !== '0) begin
            failures++; $display("FAIL boot_ignore_req cnt=%h pc=%h exp=0/0", flush_count, redirect_pc);
        end
    endtask

    task automatic test_stall_chain();
        logic [3:0] exp_tab [4] = '{4'b1110, 4'b1000, 4'b1100, 4'b1111};
        for (int k = 0; k < 4; k++) begin
            clear_inputs();
            case (k)
                0: mp_rn_full = 1;
                1: if_id_full = 1;
                2: id_mp_full = 1;
                default: begin rn_busy = 1; sched_req = 1; end
            endcase
            #1;
            checks++;
            if ({if_stall, id_stall, mp_stall, rn_stall} !== exp_tab[k]) begin
                failures++; $display("FAIL stall_chain_%0d got=%b exp=%b", k, {if_stall, id_stall, mp_stall, rn_stall}, exp_tab[k]);
            end
        end
        checks++;
        if (schedule_en !== 1'b0) begin
            failures++; $display("FAIL sched_busy got=%b exp=0", schedule_en);
        end
        rn_busy = 0; #1;
        checks++;
        if (schedule_en !== 1'b1) begin
            failures++; $display("FAIL sched_grant got=%b exp=1", schedule_en);
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        int nflush;
        branch = 1; pc_override = 32'h0000_2000; tick();
        branch = 0; pc_override = 32'h0000_7777; sched_req = 1;
        nflush = 0;
        for (int i = 0; i < 20 && flush === 1'b1; i++) begin
            if ({if_stall, id_stall, mp_stall, rn_stall, schedule_en, redirect_valid} === 6'b111100) nflush++;
            tick();
        end
        checks++;
        if (nflush !== FL) begin
            failures++; $display("FAIL branch_flush_len got=%0d exp=%0d", nflush, FL);
        end
        checks++;
        if ({redirect_valid, flush, rn_stall, schedule_en} !== 4'b1010 || redirect_pc !== 32'h0000_2000) begin
            failures++; $display("FAIL branch_redirect got=%b pc=%h exp=1010 pc=00002000", {redirect_valid, flush, rn_stall, schedule_en}, redirect_pc);
        end
        jump = 1; tick(); jump = 0; #1;
        checks++;
        if ({redirect_valid, flush, rn_stall, schedule_en} !== 4'b0001 || flush_count !== 16'd1) begin
            failures++; $display("FAIL branch_back_to_run got=%b cnt=%h exp=0001 cnt=1", {redirect_valid, flush, rn_stall, schedule_en}, flush_count);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        branch = 1; jump = 1; exception = 1; pc_override = 32'h0000_3000; tick();
        clear_inputs();
        checks++;
        if (redirect_pc !== EXC || flush_count !== 16'd1 || flush !== 1'b1) begin
            failures++; $display("FAIL priority pc=%h cnt=%h fl=%b exp=%h/1/1", redirect_pc, flush_count, flush, EXC);
        end
        repeat (FL + 1) tick();
    endtask

    task automatic test_exc_in_flush();
        int nflush;
        do_reset();
        branch = 1; pc_override = 32'h0000_2000; tick(); branch = 0;
        nflush = 0;
        for (int i = 0; i < 20 && flush === 1'b1; i++) begin
            nflush++;
            exception = (i == 0);
            jump      = (i == 2);
            pc_override = 32'h0000_9000;
            tick();
        end
        clear_inputs();
        checks++;
        if (nflush !== FL + 1) begin
            failures++; $display("FAIL exc_flush_len got=%0d exp=%0d", nflush, FL + 1);
        end
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== EXC || flush_count !== 16'd2) begin
            failures++; $display("FAIL exc_flush_result rv=%b pc=%h cnt=%h exp=1/%h/2", redirect_valid, redirect_pc, flush_count, EXC);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit saw;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            branch = 1; pc_override = 32'h0000_4000; tick(); branch = 0;
            repeat ((k == 0) ? 1 : FL) tick();
            checks++;
            if ({flush, redirect_valid} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL abort_setup_%0d got=%b", k, {flush, redirect_valid});
            end
            #2 rst = 0; #1;
            checks++;
            if ({if_stall, id_stall, mp_stall, rn_stall, flush, redirect_valid, schedule_en} !== 7'b1111000) begin
                failures++; $display("FAIL async_reset_%0d got=%b exp=1111000", k, {if_stall, id_stall, mp_stall, rn_stall, flush, redirect_valid, schedule_en});
            end
            checks++;
            if (redirect_pc !== '0 || flush_count !== 16'd0) begin
                failures++; $display("FAIL async_reset_regs_%0d pc=%h cnt=%h exp=0/0", k, redirect_pc, flush_count);
            end
            tick(); rst = 1;
            saw = 0;
            for (int c = 0; c < BOOT + FL + 4; c++) begin
                if (redirect_valid === 1'b1 || flush === 1'b1) saw = 1;
                tick();
            end
            checks++;
            if (saw || rn_stall !== 1'b0) begin
                failures++; $display("FAIL abort_no_pulse_%0d saw=%b rn=%b exp=0/0", k, saw, rn_stall);
            end
        end
    endtask

    task automatic test_random();
        logic in_run, e_rn, e_mp, e_id, e_if, e_fl, e_rv, e_se;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            branch      = ($urandom_range(0, 11) == 0);
            jump        = ($urandom_range(0, 11) == 0);
            exception   = ($urandom_range(0, 19) == 0);
            pc_override = $urandom;
            if_id_full  = $urandom_range(0, 1);
            id_mp_full  = $urandom_range(0, 1);
            mp_rn_full  = ($urandom_range(0, 3) == 0);
            rn_busy     = ($urandom_range(0, 3) == 0);
            sched_req   = $urandom_range(0, 1);
            #1;
            in_run = (m.boot_left == 0 && m.flush_left == 0 && !m.redir);
            e_rn = in_run ? rn_busy : 1'b1;
            e_mp = in_run ? (rn_busy | mp_rn_full) : 1'b1;
            e_id = in_run ? (rn_busy | mp_rn_full | id_mp_full) : 1'b1;
            e_if = in_run ? (rn_busy | mp_rn_full | id_mp_full | if_id_full) : 1'b1;
            e_fl = (m.boot_left == 0 && m.flush_left > 0);
            e_rv = (m.boot_left == 0 && m.flush_left == 0 && m.redir);
            e_se = in_run & sched_req & ~rn_busy;
            checks++;
            if ({if_stall, id_stall, mp_stall, rn_stall} !== {e_if, e_id, e_mp, e_rn}) begin
                failures++; $display("FAIL rand_stalls cyc=%0d got=%b exp=%b", i, {if_stall, id_stall, mp_stall, rn_stall}, {e_if, e_id, e_mp, e_rn});
            end
            checks++;
            if ({flush, redirect_valid, schedule_en} !== {e_fl, e_rv, e_se}) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", i, {flush, redirect_valid, schedule_en}, {e_fl, e_rv, e_se});
            end
            checks++;
            if (redirect_pc !== m.pc || flush_count !== 16'(m.count)) begin
                failures++; $display("FAIL rand_regs cyc=%0d pc=%h cnt=%h exp=%h/%h", i, redirect_pc, flush_count, m.pc, 16'(m.count));
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        branch = 1; pc_override = 32'h0000_1234; tick(); branch = 0;
        exception = 1;
        repeat (65533) tick();
        checks++;
        if (flush_count !== 16'hFFFE) begin
            failures++; $display("FAIL sat_pre got=%h exp=fffe", flush_count);
        end
        tick();
        checks++;
        if (flush_count !== 16'hFFFF) begin
            failures++; $display("FAIL sat_reach got=%h exp=ffff", flush_count);
        end
        repeat (10) tick();
        checks++;
        if (flush_count !== 16'hFFFF || flush !== 1'b1) begin
            failures++; $display("FAIL sat_hold cnt=%h fl=%b exp=ffff/1", flush_count, flush);
        end
        exception = 0;
        repeat (FL + 2) tick();
        checks++;
        if (flush_count !== 16'hFFFF || rn_stall !== 1'b0 || redirect_pc !== EXC) begin
            failures++; $display("FAIL sat_exit cnt=%h rn=%b pc=%h exp=ffff/0/%h", flush_count, rn_stall, redirect_pc, EXC);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_boot();
        test_stall_chain();
        test_branch();
        test_priority();
        test_exc_in_flush();
        test_async_reset();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
